// File: rtl/dense_layer_seq_if.sv
// Handshake and memory-port bundle for the sequential dense layer.
// The compute block attaches through the slave modport. The environment
// (the input producer, the output consumer and the weight/bias memories)
// attaches through the master modport.
interface dense_layer_seq_if #(
  parameter int IN_FEATURES  = 128,
  parameter int OUT_FEATURES = 64,
  parameter int DATA_W       = 8,
  parameter int W_W          = 16,
  parameter int ACC_W        = 48
);
  localparam int WA_W = (IN_FEATURES * OUT_FEATURES > 1) ? $clog2(IN_FEATURES * OUT_FEATURES) : 1;
  localparam int BA_W = (OUT_FEATURES > 1) ? $clog2(OUT_FEATURES) : 1;

  // input vector stream
  logic [IN_FEATURES*DATA_W-1:0]  data_in;
  logic                           in_valid;
  logic                           in_ready;

  // weight memory read port
  logic [WA_W-1:0]                w_addr;
  logic                           w_rd_en;
  logic signed [W_W-1:0]          w_rdata;

  // bias memory read port
  logic [BA_W-1:0]                b_addr;
  logic                           b_rd_en;
  logic signed [ACC_W-1:0]        b_rdata;

  // result vector stream
  logic [OUT_FEATURES*DATA_W-1:0] data_out;
  logic                           out_valid;
  logic                           out_ready;

  logic                           busy;

  modport slave (
    input  data_in, in_valid,
    output in_ready,
    output w_addr, w_rd_en,
    input  w_rdata,
    output b_addr, b_rd_en,
    input  b_rdata,
    output data_out, out_valid,
    input  out_ready,
    output busy
  );

  modport master (
    output data_in, in_valid,
    input  in_ready,
    input  w_addr, w_rd_en,
    output w_rdata,
    input  b_addr, b_rd_en,
    output b_rdata,
    input  data_out, out_valid,
    output out_ready,
    input  busy
  );
endinterface

// File: rtl/dense_layer_seq.sv
// Sequential fully-connected layer: one multiply-accumulate per cycle.
// Neuron i takes IN_FEATURES+2 cycles. Cycle 0 issues the bias read and
// the first weight read. Weight reads continue up to cycle IN_FEATURES-1,
// each read returns one cycle later, and the scaled, clamped result is
// written to output element i in the last cycle.
// All handshake and memory-strobe outputs come straight from flops. Their
// next values are derived from the next FSM state.
module dense_layer_seq #(
  parameter int IN_FEATURES  = 128,
  parameter int OUT_FEATURES = 64,
  parameter int DATA_W       = 8,
  parameter int W_W          = 16,
  parameter int ACC_W        = 48,
  parameter int FRAC_SHIFT   = 16,
  parameter int RELU         = 1
) (
  input  logic              clk,
  input  logic              rst,
  dense_layer_seq_if.slave  bus
);

  localparam int IN_W   = IN_FEATURES * DATA_W;
  localparam int OUT_W  = OUT_FEATURES * DATA_W;
  localparam int WA_W   = (IN_FEATURES * OUT_FEATURES > 1) ? $clog2(IN_FEATURES * OUT_FEATURES) : 1;
  localparam int BA_W   = (OUT_FEATURES > 1) ? $clog2(OUT_FEATURES) : 1;
  localparam int CYC_W  = $clog2(IN_FEATURES + 2);
  localparam int PROD_W = DATA_W + W_W + 1;

  localparam logic [CYC_W-1:0] CYC_LAST_RD = CYC_W'(IN_FEATURES - 1);
  localparam logic [CYC_W-1:0] CYC_LAST    = CYC_W'(IN_FEATURES + 1);
  localparam logic [BA_W-1:0]  NEURON_LAST = BA_W'(OUT_FEATURES - 1);

  // clamp bounds, expressed at accumulator width for signed comparison
  localparam logic signed [ACC_W-1:0] U_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_OUTPUT
  } state_t;

  state_t                   state_q, state_d;
  logic [BA_W-1:0]          neuron_q, neuron_d;
  logic [CYC_W-1:0]         cyc_q, cyc_d;
  logic [IN_W-1:0]          x_q, x_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]         data_out_q, data_out_d;
  logic [WA_W-1:0]          w_addr_q, w_addr_d;
  logic                     w_rd_en_q, w_rd_en_d;
  logic                     b_rd_en_q, b_rd_en_d;
  logic                     w_vld_q, w_vld_d;
  logic                     b_vld_q, b_vld_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;

  // The input register rotates by one element per returned weight. The
  // current element therefore always sits in the low slot, and after
  // IN_FEATURES returns the register is back in its original order for
  // the next neuron.
  logic [IN_W-1:0] x_rot;
  if (IN_FEATURES > 1) begin : g_rot
    assign x_rot = {x_q[DATA_W-1:0], x_q[IN_W-1:DATA_W]};
  end else begin : g_no_rot
    assign x_rot = x_q;
  end

  logic signed [DATA_W:0]    x_ext;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   shifted;
  logic [DATA_W-1:0]         result;

  // Datapath: multiply-accumulate, then the scale and clamp of the finished sum.
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    x_ext    = signed'({1'b0, x_q[DATA_W-1:0]});
    prod     = PROD_W'(x_ext) * PROD_W'(bus.w_rdata);
    acc_base = b_vld_q ? bus.b_rdata : acc_q;
    acc_d    = acc_q;
    if (w_vld_q) begin
      acc_d = acc_base + ACC_W'(prod);
    end

    shifted = acc_q >>> FRAC_SHIFT;
    result  = shifted[DATA_W-1:0];
    if (RELU != 0) begin
      if (shifted[ACC_W-1]) begin
        result = '0;
      end else if (shifted > U_MAX) begin
        result = '1;
      end
    end else begin
      if (shifted > S_MAX) begin
        result = S_MAX[DATA_W-1:0];
      end else if (shifted < S_MIN) begin
        result = S_MIN[DATA_W-1:0];
      end
    end
  end

  // FSM next state, counters, address generation and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    neuron_d   = neuron_q;
    cyc_d      = cyc_q;
    x_d        = x_q;
    data_out_d = data_out_q;
    w_addr_d   = w_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d  = S_COMPUTE;
          x_d      = bus.data_in;
          neuron_d = '0;
          cyc_d    = '0;
          w_addr_d = '0;
        end
      end
      S_COMPUTE: begin
        if (w_vld_q) begin
          x_d = x_rot;
        end
        // The address is a running count, so it is simply i*IN_FEATURES+j.
        if (w_rd_en_q) begin
          w_addr_d = w_addr_q + WA_W'(1);
        end
        if (cyc_q == CYC_LAST) begin
          for (int i = 0; i < OUT_FEATURES; i++) begin
            if (BA_W'(i) == neuron_q) begin
              data_out_d[i*DATA_W +: DATA_W] = result;
            end
          end
          cyc_d = '0;
          if (neuron_q == NEURON_LAST) begin
            state_d = S_OUTPUT;
          end else begin
            neuron_d = neuron_q + BA_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_OUTPUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_OUTPUT);
    busy_d      = (state_d != S_IDLE);
    w_rd_en_d   = (state_d == S_COMPUTE) && (cyc_d <= CYC_LAST_RD);
    b_rd_en_d   = (state_d == S_COMPUTE) && (cyc_d == '0);
    // read data returns exactly one cycle after its strobe
    w_vld_d     = w_rd_en_q;
    b_vld_d     = b_rd_en_q;
  end

  // State register. Reset wins over every other event.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      neuron_q    <= '0;
      cyc_q       <= '0;
      // NOTE: the input vector register is reset too, so no operand from an abandoned run survives.
      x_q         <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      w_addr_q    <= '0;
      w_rd_en_q   <= 1'b0;
      b_rd_en_q   <= 1'b0;
      w_vld_q     <= 1'b0;
      b_vld_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      neuron_q    <= neuron_d;
      cyc_q       <= cyc_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      data_out_q  <= data_out_d;
      w_addr_q    <= w_addr_d;
      w_rd_en_q   <= w_rd_en_d;
      b_rd_en_q   <= b_rd_en_d;
      w_vld_q     <= w_vld_d;
      b_vld_q     <= b_vld_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.data_out  = data_out_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.w_rd_en   = w_rd_en_q;
  assign bus.b_addr    = neuron_q;
  assign bus.b_rd_en   = b_rd_en_q;

endmodule
